// File: rtl/hazard_scoreboard.sv
// Decode-side hazard/forwarding controller built on a scoreboard shift register of in-flight writes.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int FWD_STAGES = 3,
   parameter int LOAD_STAGE = 2,
   parameter int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic [REG_ADDR_W-1:0] id_dst,
   input  logic                  id_reg_write,
   input  logic                  id_load,
   input  logic                  branch_taken,
   output logic                  stall,
   output logic                  flush_if_id,
   output logic [FWD_SEL_W-1:0]  fwd_a,
   output logic [FWD_SEL_W-1:0]  fwd_b
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]           stall_count,
   output logic [15:0]           flush_count
`endif
);

   logic                  sb_valid [FWD_STAGES];
   logic                  sb_wr    [FWD_STAGES];
   logic                  sb_load  [FWD_STAGES];
   logic [REG_ADDR_W-1:0] sb_dst   [FWD_STAGES];

   logic haz_a;
   logic haz_b;

   // Scan oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (id_use_rs && (id_rs != '0) && sb_valid[k] && sb_wr[k] && (sb_dst[k] == id_rs)) begin
            fwd_a = FWD_SEL_W'(k + 1);
            haz_a = sb_load[k] && (k < LOAD_STAGE);
         end
         if (id_use_rt && (id_rt != '0) && sb_valid[k] && sb_wr[k] && (sb_dst[k] == id_rt)) begin
            fwd_b = FWD_SEL_W'(k + 1);
            haz_b = sb_load[k] && (k < LOAD_STAGE);
         end
      end
   end

   assign stall       = id_valid & (haz_a | haz_b);
   assign flush_if_id = branch_taken & id_valid & ~stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < FWD_STAGES; k++) begin
            sb_valid[k] <= 1'b0;
            sb_wr[k]    <= 1'b0;
            sb_load[k]  <= 1'b0;
            sb_dst[k]   <= '0;
         end
      end else if (enable) begin
         for (int k = FWD_STAGES - 1; k > 0; k--) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_wr[k]    <= sb_wr[k-1];
            sb_load[k]  <= sb_load[k-1];
            sb_dst[k]   <= sb_dst[k-1];
         end
         // A stalled decode slot enters EX as a bubble.
         sb_valid[0] <= id_valid & ~stall;
         sb_wr[0]    <= id_reg_write;
         sb_load[0]  <= id_load;
         sb_dst[0]   <= id_dst;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else if (enable) begin
         if (stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         if (flush_if_id && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule
